// File: rtl/insmem_accum_sequencer_pkg.sv
// seq_pkg: shared state encoding and default widths for the accumulate sequencer
package seq_pkg;
  localparam int W_DEF = 32;
  localparam int AW_DEF = 32;
  localparam int CW_DEF = 16;
  typedef enum logic [2:0] {IDLE, CLR, FETCH, ADD, DONE} state_t;
endpackage

// File: rtl/insmem_seq_counter.sv
// insmem_seq_counter: word index with last-word detect against the captured count
module insmem_seq_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic [CW-1:0] count,
  output logic [CW-1:0] idx,
  output logic          last
);
  always_ff @(posedge clk or posedge rst)
    if (rst) idx <= '0;
    else if (clear) idx <= '0;
    else if (inc) idx <= idx + CW'(1);
  assign last = idx == count - CW'(1);
endmodule

// File: rtl/insmem_accum_sequencer.sv
// insmem_accum_sequencer: drives memory -> register -> adder datapath to sum count words from base_addr
module insmem_accum_sequencer
  import seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          carry_flg,
  output logic          ovf_flg,
  output logic          mem_e,
  output logic          mem_l,
  output logic [AW-1:0] mem_addr,
  output logic          reg_l,
  output logic          reg_e,
  output logic          reg_w,
  output logic [W-1:0]  reg_r,
  output logic          add_cin,
  input  logic [W-1:0]  add_sum,
  input  logic          add_cout,
  input  logic          add_ovf
);
  state_t state;
  logic [AW-1:0] base;
  logic [CW-1:0] cnt, idx;
  logic last;

  insmem_seq_counter #(.CW(CW)) u_cnt (
    .clk(clk), .rst(rst), .clear(state == CLR), .inc(state == ADD && !last),
    .count(cnt), .idx(idx), .last(last)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      base <= '0;
      cnt <= '0;
      result <= '0;
      carry_flg <= 1'b0;
      ovf_flg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base <= base_addr;
          cnt <= count;
          result <= '0;
          carry_flg <= 1'b0;
          ovf_flg <= 1'b0;
          busy <= 1'b1;
          state <= count == '0 ? DONE : CLR;
        end
        CLR: state <= FETCH;
        FETCH: state <= ADD;
        ADD: begin
          result <= add_sum;
          carry_flg <= carry_flg | add_cout;
          ovf_flg <= ovf_flg | add_ovf;
          state <= last ? DONE : FETCH;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  // strobes decode straight from state so the datapath sees them in the same cycle
  always_comb begin
    done = state == DONE;
    mem_e = state == FETCH;
    mem_l = state == FETCH;
    mem_addr = state == FETCH ? base + AW'(idx) : '0;
    reg_l = state == CLR || state == ADD;
    reg_r = state == ADD ? add_sum : '0;
    reg_e = 1'b0;
    reg_w = 1'b0;
    add_cin = 1'b0;
  end
endmodule
